// File: rtl/dct_pkg.sv
// Shared definitions for the 2-D DCT datapath: block size, index and sample types.
package dct_pkg;

  localparam int DCT_N      = 8;
  localparam int DCT_DATA_W = 32;

  typedef logic [2:0]                   idx_t;
  typedef logic signed [DCT_DATA_W-1:0] sample_t;

endpackage

// File: rtl/dct_tbuf_bank.sv
// One 8x8 sample bank: a whole row is written per cycle, a whole column is read per cycle.
module dct_tbuf_bank
  import dct_pkg::*;
#(
  parameter int DATA_W = DCT_DATA_W,
  parameter int N      = DCT_N
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  idx_t                     wr_row,
  input  logic signed [DATA_W-1:0] wr_data [N],
  input  idx_t                     rd_col,
  output logic signed [DATA_W-1:0] rd_data [N]
);

  logic signed [DATA_W-1:0] mem [N][N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          mem[r][c] <= '0;
        end
      end
    end else if (we) begin
      for (int c = 0; c < N; c++) begin
        mem[wr_row][c] <= wr_data[c];
      end
    end
  end

  // Column read is combinational so the output follows rd_col with no extra cycle.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      rd_data[r] = mem[r][rd_col];
    end
  end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer: rows in from the row DCT, columns out to the column DCT.
module dct_transpose_buf
  import dct_pkg::*;
#(
  parameter int DATA_W = DCT_DATA_W,
  parameter int N      = DCT_N
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_row0,
  input  logic signed [DATA_W-1:0] in_row1,
  input  logic signed [DATA_W-1:0] in_row2,
  input  logic signed [DATA_W-1:0] in_row3,
  input  logic signed [DATA_W-1:0] in_row4,
  input  logic signed [DATA_W-1:0] in_row5,
  input  logic signed [DATA_W-1:0] in_row6,
  input  logic signed [DATA_W-1:0] in_row7,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_col0,
  output logic signed [DATA_W-1:0] out_col1,
  output logic signed [DATA_W-1:0] out_col2,
  output logic signed [DATA_W-1:0] out_col3,
  output logic signed [DATA_W-1:0] out_col4,
  output logic signed [DATA_W-1:0] out_col5,
  output logic signed [DATA_W-1:0] out_col6,
  output logic signed [DATA_W-1:0] out_col7,
  output logic                     out_last
);

  localparam idx_t LAST = idx_t'(N - 1);

  logic       wr_bank;
  logic       rd_bank;
  idx_t       wr_row;
  idx_t       rd_col;
  logic [1:0] full;
  logic [1:0] full_nxt;

  logic wr_acc;
  logic rd_acc;

  logic signed [DATA_W-1:0] row_data [N];
  logic signed [DATA_W-1:0] rd_data0 [N];
  logic signed [DATA_W-1:0] rd_data1 [N];
  logic signed [DATA_W-1:0] col_data [N];

  assign row_data[0] = in_row0;
  assign row_data[1] = in_row1;
  assign row_data[2] = in_row2;
  assign row_data[3] = in_row3;
  assign row_data[4] = in_row4;
  assign row_data[5] = in_row5;
  assign row_data[6] = in_row6;
  assign row_data[7] = in_row7;

  // Handshake flags decode from registered state only, never from in_valid/out_ready.
  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign out_last  = out_valid && (rd_col == LAST);

  assign wr_acc = in_valid && in_ready;
  assign rd_acc = out_valid && out_ready;

  dct_tbuf_bank #(.DATA_W(DATA_W), .N(N)) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_acc && !wr_bank),
    .wr_row  (wr_row),
    .wr_data (row_data),
    .rd_col  (rd_col),
    .rd_data (rd_data0)
  );

  dct_tbuf_bank #(.DATA_W(DATA_W), .N(N)) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_acc && wr_bank),
    .wr_row  (wr_row),
    .wr_data (row_data),
    .rd_col  (rd_col),
    .rd_data (rd_data1)
  );

  always_comb begin
    for (int r = 0; r < N; r++) begin
      col_data[r] = rd_bank ? rd_data1[r] : rd_data0[r];
    end
  end

  assign out_col0 = col_data[0];
  assign out_col1 = col_data[1];
  assign out_col2 = col_data[2];
  assign out_col3 = col_data[3];
  assign out_col4 = col_data[4];
  assign out_col5 = col_data[5];
  assign out_col6 = col_data[6];
  assign out_col7 = col_data[7];

  // A completing write and a completing read always hit different banks, so both apply.
  always_comb begin
    full_nxt = full;
    if (wr_acc && (wr_row == LAST)) full_nxt[wr_bank] = 1'b1;
    if (rd_acc && (rd_col == LAST)) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_row  <= '0;
      rd_col  <= '0;
      full    <= 2'b00;
    end else begin
      full <= full_nxt;
      if (wr_acc) begin
        wr_row <= wr_row + idx_t'(1);
        if (wr_row == LAST) wr_bank <= !wr_bank;
      end
      if (rd_acc) begin
        rd_col <= rd_col + idx_t'(1);
        if (rd_col == LAST) rd_bank <= !rd_bank;
      end
    end
  end

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Randomized bench for dct_transpose_buf against a block-queue reference model.
module tb_dct_transpose_buf;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] ir [8];
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] oc [8];
  logic               out_last;

  int n_checks;
  int n_fail;

  typedef logic [31:0] blk_t [64];
  blk_t q[$];
  blk_t cur;
  int   cur_rows;
  int   rd_col_m;

  dct_transpose_buf #(.DATA_W(32), .N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row0   (ir[0]),
    .in_row1   (ir[1]),
    .in_row2   (ir[2]),
    .in_row3   (ir[3]),
    .in_row4   (ir[4]),
    .in_row5   (ir[5]),
    .in_row6   (ir[6]),
    .in_row7   (ir[7]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col0  (oc[0]),
    .out_col1  (oc[1]),
    .out_col2  (oc[2]),
    .out_col3  (oc[3]),
    .out_col4  (oc[4]),
    .out_col5  (oc[5]),
    .out_col6  (oc[6]),
    .out_col7  (oc[7]),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    cur_rows = 0;
    rd_col_m = 0;
  endtask

  task automatic check_outputs();
    bit ev;
    ev = (q.size() > 0);
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_last", 32'(out_last), 32'(ev && rd_col_m == 7));
    if (ev) begin
      for (int r = 0; r < 8; r++) begin
        chk($sformatf("col%0d_row%0d", rd_col_m, r), oc[r], q[0][r*8 + rd_col_m]);
      end
    end
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic step(input bit iv, input bit ordy);
    bit wacc, racc;
    check_outputs();
    in_valid  = iv;
    out_ready = ordy;
    wacc = iv && (q.size() < 2);
    racc = ordy && (q.size() > 0);
    @(posedge clk);
    if (racc) begin
      rd_col_m++;
      if (rd_col_m == 8) begin
        void'(q.pop_front());
        rd_col_m = 0;
      end
    end
    if (wacc) begin
      for (int c = 0; c < 8; c++) cur[cur_rows*8 + c] = ir[c];
      cur_rows++;
      if (cur_rows == 8) begin
        q.push_back(cur);
        cur_rows = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_rows();
    for (int c = 0; c < 8; c++) ir[c] = $urandom;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_last"}, 32'(out_last), 32'd0);
    for (int r = 0; r < 8; r++) chk($sformatf("%s_col_r%0d", tag, r), oc[r], 32'd0);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) ir[c] = '0;
    model_clear();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    // Single block with element (r,c) = 8r+c, drained after it is complete.
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) ir[c] = 32'(8*r + c);
      step(1'b1, 1'b0);
    end
    in_valid = 1'b0;
    chk("single_valid_after_8th", 32'(out_valid), 32'd1);
    step(1'b0, 1'b1);
    for (int r = 0; r < 8; r++) chk($sformatf("single_col1_r%0d", r), oc[r], 32'(8*r + 1));
    repeat (7) step(1'b0, 1'b1);

    // Streaming: four back-to-back blocks with both sides always ready.
    for (int i = 0; i < 32; i++) begin
      rand_rows();
      step(1'b1, 1'b1);
    end
    repeat (10) step(1'b0, 1'b1);

    // Backpressure: 17 rows offered with the read side stalled, then drain.
    for (int i = 0; i < 17; i++) begin
      rand_rows();
      step(1'b1, 1'b0);
    end
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    repeat (18) step(1'b0, 1'b1);

    // Stall hold: out_ready toggles every cycle while rows stream in.
    for (int i = 0; i < 40; i++) begin
      rand_rows();
      step(1'b1, 1'(i % 2));
    end
    repeat (34) step(1'b0, 1'(i_toggle(0)));
    repeat (4) step(1'b0, 1'b1);

    // Simultaneous completion: read of bank 0 and write of bank 1 end together.
    for (int i = 0; i < 8; i++) begin
      rand_rows();
      step(1'b1, 1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      rand_rows();
      step(1'b1, 1'b1);
    end
    in_valid = 1'b0;
    chk("simul_out_valid", 32'(out_valid), 32'd1);
    chk("simul_in_ready", 32'(in_ready), 32'd1);
    repeat (9) step(1'b0, 1'b1);

    // Reset mid-block after five rows.
    for (int i = 0; i < 5; i++) begin
      rand_rows();
      step(1'b1, 1'b0);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_clear();
    check_reset_state("midrst");
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("postrst");
    for (int i = 0; i < 8; i++) begin
      rand_rows();
      step(1'b1, 1'b0);
    end
    repeat (9) step(1'b0, 1'b1);

    // Random traffic on both sides.
    for (int i = 0; i < 400; i++) begin
      rand_rows();
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    end
    repeat (20) step(1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  function automatic int i_toggle(input int dummy);
    return ($urandom_range(0, 1) + dummy);
  endfunction

endmodule
